mips_cpu_muldiv_seq: RTL and testbench

Multi-cycle sequencer that owns the HI/LO register pair and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO for the multicycle CPU. It accepts one operation per handshake and iterates over 32 cycles on unsigned magnitudes with a final sign fix-up. It stalls the control FSM when HI/LO is read while an operation is in flight. The ALU reads HI/LO through this block's `rd_data` output.

---
 rtl/mips_cpu_pkg.sv | 24 ++
 rtl/mips_cpu_muldiv_step.sv | 31 +++
 rtl/mips_cpu_muldiv_seq.sv | 129 ++++++++++++
 tb/tb_mips_cpu_muldiv_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU definitions: HI/LO sequencer opcodes, states and constants.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MFHI  = 3'b110,
    OP_MFLO  = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } muldiv_state_t;

  localparam logic [31:0] DIV0_LO = 32'hFFFFFFFF;

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// One iteration of the HI/LO datapath: radix-2 shift-add multiply or restoring divide.
module mips_cpu_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Multiply: acc_lo holds the unconsumed multiplier bits, acc_hi the running sum.
  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted - {1'b0, m};
    if (is_div) begin
      nxt_hi = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      {nxt_hi, nxt_lo} = {sum, acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv_seq.sv
// HI/LO owner for the multicycle CPU: sequences MULT/DIV over WIDTH cycles and serves MT/MF ops.
module mips_cpu_muldiv_seq
  import mips_cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             accept,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  muldiv_state_t    state;
  muldiv_op_t       opc;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, m;
  logic             is_div, rsign, remsign;
  logic             sgn;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;
  logic [2*WIDTH-1:0] prod_neg;

  assign opc      = muldiv_op_t'(op);
  assign busy     = (state != IDLE);
  assign done     = (state == FIX);
  assign accept   = start && !busy;
  assign stall    = start && busy && (opc == OP_MFHI || opc == OP_MFLO);
  assign sgn      = (opc == OP_MULT) || (opc == OP_DIV);
  assign abs_a    = (sgn && a[WIDTH-1]) ? -a : a;
  assign abs_b    = (sgn && b[WIDTH-1]) ? -b : b;
  assign prod_neg = -{acc_hi, acc_lo};

  always_comb begin
    rd_data = '0;
    if (opc == OP_MFHI) rd_data = hi;
    else if (opc == OP_MFLO) rd_data = lo;
  end

  mips_cpu_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (state == DIV),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .m      (m),
    .nxt_hi (nxt_hi),
    .nxt_lo (nxt_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      m       <= '0;
      is_div  <= 1'b0;
      rsign   <= 1'b0;
      remsign <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (opc)
              OP_MULT, OP_MULTU: begin
                state  <= MUL;
                cnt    <= '0;
                acc_hi <= '0;
                acc_lo <= abs_b;
                m      <= abs_a;
                is_div <= 1'b0;
                rsign  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                remsign <= 1'b0;
              end
              OP_DIV, OP_DIVU: begin
                cnt     <= '0;
                m       <= abs_b;
                is_div  <= 1'b1;
                remsign <= sgn && a[WIDTH-1];
                // Divide by zero skips iteration; the remainder fix-up restores the original a.
                if (b == '0) begin
                  state  <= FIX;
                  acc_hi <= abs_a;
                  acc_lo <= DIV0_LO;
                  rsign  <= 1'b0;
                end else begin
                  state  <= DIV;
                  acc_hi <= '0;
                  acc_lo <= abs_a;
                  rsign  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                end
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          if (is_div) begin
            hi <= remsign ? -acc_hi : acc_hi;
            lo <= rsign ? -acc_lo : acc_lo;
          end else begin
            {hi, lo} <= rsign ? prod_neg : {acc_hi, acc_lo};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv_seq.sv
// Directed bench for the HI/LO sequencer with a queue of expected {hi,lo} results.
module tb_mips_cpu_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        accept, busy, stall, done;
  logic [31:0] hi, lo, rd_data;

  int checks = 0;
  int passes = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  mips_cpu_muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .accept  (accept),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .rd_data (rd_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %h required %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                        input int exp_lat);
    int k;
    int done_k;
    logic [63:0] e;
    sb.push_back({eh, el});
    op = o; a = x; b = y; start = 1'b1;
    #1;
    chk({tag, " accept"}, 32'(accept), 32'd1);
    tick;
    start = 1'b0;
    k = 1;
    done_k = 0;
    while (busy && k < 80) begin
      if (done) done_k = k;
      tick;
      k++;
    end
    chk({tag, " busy_cycles"}, 32'(k - 1), 32'(exp_lat));
    chk({tag, " done_at"}, 32'(done_k), 32'(exp_lat));
    e = sb.pop_front();
    chk({tag, " hi"}, hi, e[63:32]);
    chk({tag, " lo"}, lo, e[31:0]);
  endtask

  initial begin
    int k;
    int n;
    logic [63:0] e;

    reset = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
    tick; tick;
    chk("rst hi", hi, 32'h0);
    chk("rst lo", lo, 32'h0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst accept", 32'(accept), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    reset = 1'b0;
    tick;

    run_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
    run_op("mult_neg",  3'b000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 33);
    run_op("div_neg",   3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    run_op("divu",      3'b011, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 33);
    run_op("div_ovf",   3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);
    run_op("divu_by0",  3'b011, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1);
    run_op("div_by0",   3'b010, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1);

    // MFLO held from T+5 of a MULT: stalls until busy drops, then returns the new lo
    sb.push_back({32'hFFFFFFFF, 32'hFFFFFFEB});
    op = 3'b000; a = 32'hFFFFFFFD; b = 32'd7; start = 1'b1;
    #1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    op = 3'b111; start = 1'b1;
    #1;
    chk("mflo stall", 32'(stall), 32'd1);
    chk("mflo no_accept", 32'(accept), 32'd0);
    k = 5;
    n = 0;
    while (!accept && k < 80) begin
      if (stall) n++;
      tick;
      k++;
    end
    e = sb.pop_front();
    chk("mflo accept_at", 32'(k), 32'd34);
    chk("mflo stall_cycles", 32'(n), 32'd29);
    chk("mflo busy_low", 32'(busy), 32'd0);
    chk("mflo rd_data", rd_data, e[31:0]);
    chk("mflo hi", hi, e[63:32]);
    tick;
    start = 1'b0;

    op = 3'b100; a = 32'h00001234; start = 1'b1;
    #1;
    chk("mthi accept", 32'(accept), 32'd1);
    tick;
    start = 1'b0;
    chk("mthi hi", hi, 32'h00001234);
    chk("mthi busy", 32'(busy), 32'd0);
    op = 3'b101; a = 32'h0000CAFE; start = 1'b1;
    #1;
    tick;
    start = 1'b0;
    chk("mtlo lo", lo, 32'h0000CAFE);
    chk("mtlo hi_kept", hi, 32'h00001234);
    op = 3'b110; start = 1'b1;
    #1;
    chk("mfhi accept", 32'(accept), 32'd1);
    chk("mfhi rd_data", rd_data, 32'h00001234);
    tick;
    start = 1'b0;
    chk("mfhi busy", 32'(busy), 32'd0);

    // Abort a DIV at T+10 with asynchronous reset
    op = 3'b010; a = 32'd100; b = 32'd7; start = 1'b1;
    #1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    chk("abort busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort hi", hi, 32'h0);
    chk("abort lo", lo, 32'h0);
    chk("abort busy", 32'(busy), 32'd0);
    tick; tick;
    reset = 1'b0;
    n = 0;
    repeat (40) begin
      if (done || busy) n++;
      tick;
    end
    chk("abort no_done", 32'(n), 32'd0);
    run_op("multu_after", 3'b001, 32'd2, 32'd3, 32'h00000000, 32'h00000006, 33);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
